// File: rtl/digit_bank_pkg.sv
// Shared constants and digit arithmetic for digit_bank_editor.
package digit_bank_pkg;

   localparam int unsigned DIGIT_W   = 4;
   localparam int unsigned RADIX_BCD = 10;
   localparam int unsigned RADIX_HEX = 16;

   // One modular step of a single digit; returns {carry/borrow out, next value}.
   function automatic logic [DIGIT_W:0] digit_step(input logic [DIGIT_W-1:0] v,
                                                    input logic              dir,
                                                    input int unsigned       radix);
      logic [DIGIT_W-1:0] top;
      top = DIGIT_W'(radix - 1);
      if (!dir) begin
         return (v == top) ? {1'b1, {DIGIT_W{1'b0}}} : {1'b0, v + 4'd1};
      end
      return (v == '0) ? {1'b1, top} : {1'b0, v - 4'd1};
   endfunction

   function automatic bit radix_legal(input int unsigned radix);
      return (radix == RADIX_BCD) || (radix == RADIX_HEX);
   endfunction

   // Every digit of the reset value must already be a legal digit.
   function automatic bit init_legal(input logic [31:0] init, input int unsigned n,
                                     input int unsigned radix);
      for (int i = 0; i < 8; i++) begin
         if ((i < n) && (32'(init[4*i +: 4]) >= radix)) return 1'b0;
      end
      return 1'b1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-button synchroniser, debouncer and rising-edge step request.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      sync_q, sync_d;
   logic [1:0]      vld_q, vld_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            lvl_q, lvl_d;
   logic            lvl_prev_q, lvl_prev_d;
   logic            armed_q, armed_d;
   logic            rise_q, rise_d;
   logic            s;

   assign s = sync_q[1];

   // Next-state: qualify level changes, detect a fresh debounced press.
   always_comb begin
      sync_d     = {sync_q[0], btn_i};
      vld_d      = {vld_q[0], 1'b1};
      cnt_d      = cnt_q;
      lvl_d      = lvl_q;
      lvl_prev_d = lvl_q;
      // A button held through reset must be seen released before it may step again.
      armed_d    = armed_q | (vld_q[1] & ~s);
      rise_d     = lvl_q & ~lvl_prev_q & armed_q;
      if (s == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntLast) begin
         lvl_d = s;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         vld_q      <= '0;
         cnt_q      <= '0;
         lvl_q      <= 1'b0;
         lvl_prev_q <= 1'b0;
         armed_q    <= 1'b0;
         rise_q     <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         vld_q      <= vld_d;
         cnt_q      <= cnt_d;
         lvl_q      <= lvl_d;
         lvl_prev_q <= lvl_prev_d;
         armed_q    <= armed_d;
         rise_q     <= rise_d;
      end
   end

   assign level_o = lvl_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/digit_bank_editor.sv
// Button-driven N-digit number register (radix 10 or 16), one debounced button per digit.
// Optional macro DIGIT_CARRY_EN: digit wraps ripple into the next digit and out via ovf.
module digit_bank_editor
   import digit_bank_pkg::*;
#(
   parameter int unsigned                 N_DIGITS        = 4,
   parameter int unsigned                 RADIX           = 16,
   parameter int unsigned                 DEBOUNCE_CYCLES = 20,
   parameter logic [N_DIGITS*DIGIT_W-1:0] INIT            = 16'h1234
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_DIGITS-1:0]         btn,
   input  logic                        dir,
   input  logic                        clr,
   output logic [N_DIGITS*DIGIT_W-1:0] num,
   output logic                        upd,
   output logic                        ovf
);

   if (!radix_legal(RADIX)) begin : g_bad_radix
      $error("digit_bank_editor: RADIX must be 10 or 16");
   end
   if (!init_legal(32'(INIT), N_DIGITS, RADIX)) begin : g_bad_init
      $error("digit_bank_editor: INIT has a digit >= RADIX");
   end

   logic [N_DIGITS-1:0]         p;
   logic [N_DIGITS*DIGIT_W-1:0] num_q, num_d;
   logic                        upd_q, upd_d;
   logic [DIGIT_W:0]            r0;
`ifdef DIGIT_CARRY_EN
   logic [DIGIT_W:0]            r1;
   logic                        carry;
   logic                        ovf_q, ovf_d;
`endif

   for (genvar i = 0; i < N_DIGITS; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
         .clk    (clk),
         .rst_n  (rst_n),
         .btn_i  (btn[i]),
         .level_o(),
         .rise_o (p[i])
      );
   end

   // Next-state: apply all step requests at once; clear overrides them.
   always_comb begin
      num_d = num_q;
      r0    = '0;
`ifdef DIGIT_CARRY_EN
      r1    = '0;
      carry = 1'b0;
      ovf_d = 1'b0;
`endif
      for (int i = 0; i < N_DIGITS; i++) begin
         r0 = p[i] ? digit_step(num_q[i*DIGIT_W +: DIGIT_W], dir, RADIX)
                   : {1'b0, num_q[i*DIGIT_W +: DIGIT_W]};
`ifdef DIGIT_CARRY_EN
         // Own press plus incoming carry steps the digit twice; at most one wrap.
         r1 = carry ? digit_step(r0[DIGIT_W-1:0], dir, RADIX) : {1'b0, r0[DIGIT_W-1:0]};
         num_d[i*DIGIT_W +: DIGIT_W] = r1[DIGIT_W-1:0];
         carry = r0[DIGIT_W] | r1[DIGIT_W];
`else
         num_d[i*DIGIT_W +: DIGIT_W] = r0[DIGIT_W-1:0];
`endif
      end
`ifdef DIGIT_CARRY_EN
      ovf_d = carry;
`endif
      if (clr) begin
         num_d = INIT;
`ifdef DIGIT_CARRY_EN
         ovf_d = 1'b0;
`endif
      end
      upd_d = (num_d != num_q);
   end

   // Number register and output strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_q <= INIT;
         upd_q <= 1'b0;
`ifdef DIGIT_CARRY_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         num_q <= num_d;
         upd_q <= upd_d;
`ifdef DIGIT_CARRY_EN
         ovf_q <= ovf_d;
`endif
      end
   end

   assign num = num_q;
   assign upd = upd_q;
`ifdef DIGIT_CARRY_EN
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule
